// File: rtl/dmem_arbiter.sv
// Shared data-memory arbiter: loader-only BOOT phase, then round-robin between core and loader.
// Grants are combinational; read data returns registered one cycle after the grant.
module dmem_arbiter #(
  parameter bit BOOT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [31:0] l_rdata,
  input  logic        boot_done,
  output logic        booting,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic {StBoot, StRun} state_e;

  state_e      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic        c_rvalid_q, c_rvalid_d;
  logic        l_rvalid_q, l_rvalid_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic [31:0] l_rdata_q, l_rdata_d;

  // Arbitration, memory-port mux and next state.
  always_comb begin
    c_gnt   = 1'b0;
    l_gnt   = 1'b0;
    state_d = state_q;
    unique case (state_q)
      StBoot: begin
        l_gnt = l_req;
        if (boot_done) state_d = StRun;
      end
      StRun: begin
        if (c_req && l_req) begin
          // last_gnt_q = 1 means the loader won last time, so the core goes now.
          c_gnt = last_gnt_q;
          l_gnt = ~last_gnt_q;
        end else begin
          c_gnt = c_req;
          l_gnt = l_req;
        end
      end
      default: state_d = state_q;
    endcase

    mem_we = 1'b0;
    mem_a  = 32'h0;
    mem_wd = 32'h0;
    if (c_gnt) begin
      mem_we = c_we;
      mem_a  = c_addr;
      mem_wd = c_wdata;
    end else if (l_gnt) begin
      mem_we = l_we;
      mem_a  = l_addr;
      mem_wd = l_wdata;
    end

    last_gnt_d = last_gnt_q;
    if (c_gnt)      last_gnt_d = 1'b0;
    else if (l_gnt) last_gnt_d = 1'b1;

    c_rvalid_d = c_gnt & ~c_we;
    l_rvalid_d = l_gnt & ~l_we;
    c_rdata_d  = c_rvalid_d ? mem_rd : c_rdata_q;
    l_rdata_d  = l_rvalid_d ? mem_rd : l_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT_EN ? StBoot : StRun;
      last_gnt_q <= 1'b1;
      c_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      c_rdata_q  <= 32'h0;
      l_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      c_rvalid_q <= c_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      l_rdata_q  <= l_rdata_d;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign l_rvalid = l_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign l_rdata  = l_rdata_q;
  assign booting  = (state_q == StBoot);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a BOOT_EN=1 instance with a word memory model,
// and a BOOT_EN=0 instance for the direct-to-RUN reset case.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        c_req, c_we, l_req, l_we, boot_done;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_gnt, c_rvalid, l_gnt, l_rvalid, booting, mem_we;
  logic [31:0] c_rdata, l_rdata, mem_a, mem_wd, mem_rd;

  logic        c2_req;
  logic        c2_gnt, c2_rvalid, l2_gnt, l2_rvalid, booting2, mem2_we;
  logic [31:0] c2_rdata, l2_rdata, mem2_a, mem2_wd;

  logic [31:0] mem [64];
  int          tests;
  int          fails;

  dmem_arbiter #(.BOOT_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .boot_done(boot_done), .booting(booting),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  dmem_arbiter #(.BOOT_EN(1'b0)) u_dut2 (
    .clk(clk), .rst(rst),
    .c_req(c2_req), .c_we(1'b0), .c_addr(32'h0), .c_wdata(32'h0),
    .c_gnt(c2_gnt), .c_rvalid(c2_rvalid), .c_rdata(c2_rdata),
    .l_req(1'b0), .l_we(1'b0), .l_addr(32'h0), .l_wdata(32'h0),
    .l_gnt(l2_gnt), .l_rvalid(l2_rvalid), .l_rdata(l2_rdata),
    .boot_done(1'b0), .booting(booting2),
    .mem_we(mem2_we), .mem_a(mem2_a), .mem_wd(mem2_wd), .mem_rd(32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Sample point for the current cycle.
  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst = 1'b1; boot_done = 1'b0; c2_req = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
    l_req = 1'b0; l_we = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;
    nxt();

    // BOOT: both requesting, only the loader is granted.
    rst = 1'b0; c2_req = 1'b1;
    c_req = 1'b1; c_addr = 32'h10; l_req = 1'b1; l_addr = 32'h20;
    smp();
    chk("rst_booting", booting, 1);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_l_rvalid", l_rvalid, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_l_rdata", l_rdata, 0);
    chk("noboot_c_gnt", c2_gnt, 1);
    chk("noboot_booting", booting2, 0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) smp();
      chk("boot_l_gnt", l_gnt, 1);
      chk("boot_c_gnt", c_gnt, 0);
      chk("boot_booting", booting, 1);
      nxt();
    end

    // BOOT write then read-back.
    l_we = 1'b1; l_addr = 32'h10; l_wdata = 32'hDEADBEEF;
    smp();
    chk("bw_l_gnt", l_gnt, 1);
    chk("bw_mem_we", mem_we, 1);
    chk("bw_mem_a", mem_a, 32'h10);
    chk("bw_mem_wd", mem_wd, 32'hDEADBEEF);
    nxt();
    l_we = 1'b0;
    smp();
    chk("br_l_gnt", l_gnt, 1);
    chk("br_mem_we", mem_we, 0);
    nxt();

    // boot_done with a loader read in the same cycle.
    boot_done = 1'b1;
    smp();
    chk("br_l_rvalid", l_rvalid, 1);
    chk("br_l_rdata", l_rdata, 32'hDEADBEEF);
    chk("br_c_rvalid", c_rvalid, 0);
    chk("bd_l_gnt", l_gnt, 1);
    chk("bd_c_gnt", c_gnt, 0);
    chk("bd_booting", booting, 1);
    nxt();

    // RUN round-robin: core first since the loader was granted last.
    boot_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp();
      if (k == 0) begin
        chk("run_booting", booting, 0);
        chk("bd_l_rvalid", l_rvalid, 1);
        chk("bd_l_rdata", l_rdata, 32'hDEADBEEF);
      end
      if (k == 1) begin
        chk("rr_c_rvalid", c_rvalid, 1);
        chk("rr_c_rdata", c_rdata, 32'hDEADBEEF);
      end
      chk("rr_c_gnt", c_gnt, (k % 2 == 0) ? 1 : 0);
      chk("rr_l_gnt", l_gnt, (k % 2 == 0) ? 0 : 1);
      nxt();
    end

    // Core-only writes of 1..4 to words 0..3, then read back.
    l_req = 1'b0; c_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_addr = 32'(i * 4); c_wdata = 32'(i + 1);
      smp();
      chk("cw_c_gnt", c_gnt, 1);
      if (i > 0) chk("cw_no_rvalid", c_rvalid, 0);
      nxt();
    end
    c_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_addr = 32'(i * 4);
      smp();
      chk("cr_c_gnt", c_gnt, 1);
      if (i > 0) begin
        chk("cr_c_rvalid", c_rvalid, 1);
        chk("cr_c_rdata", c_rdata, 32'(i));
      end
      nxt();
    end
    c_req = 1'b0;
    smp();
    chk("cr_last_rvalid", c_rvalid, 1);
    chk("cr_last_rdata", c_rdata, 32'h4);
    chk("idle_mem_a", mem_a, 0);
    nxt();

    // Reset in the cycle of a granted core read of 0x08.
    c_req = 1'b1; c_addr = 32'h08; rst = 1'b1;
    smp();
    chk("mr_c_gnt", c_gnt, 1);
    chk("mr_mem_a", mem_a, 32'h08);
    nxt();
    rst = 1'b0;
    smp();
    chk("mr_c_rvalid", c_rvalid, 0);
    chk("mr_c_rdata", c_rdata, 0);
    chk("mr_l_rdata", l_rdata, 0);
    chk("mr_booting", booting, 1);
    chk("mr_boot_c_gnt", c_gnt, 0);
    nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and access sequencer for the shared word-addressed data memory of the pipelined core. It multiplexes two requesters onto the single memory port: the core's memory stage and the program/data loader. After reset it runs a boot phase in which the loader has exclusive access. When the loader signals completion, it switches to round-robin sharing. Read data returns registered, one cycle after grant.

## Interface
Parameters:
- BOOT_EN, 1, 1: reset enters BOOT; 0: reset enters RUN directly.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- c_req  input  1  core request; held until c_gnt
- c_we  input  1  core write enable (1 write, 0 read)
- c_addr  input  32  core byte address; word index = c_addr[7:2]
- c_wdata  input  32  core write data
- c_gnt  output  1  core request accepted this cycle (combinational)
- c_rvalid  output  1  core read data valid (registered)
- c_rdata  output  32  core read data (registered)
- l_req, l_we, l_addr[31:0], l_wdata[31:0]  input  loader request, same meaning as the core signals
- l_gnt  output  1  loader request accepted this cycle
- l_rvalid  output  1  loader read data valid
- l_rdata  output  32  loader read data
- boot_done  input  1  loader finished; single-cycle pulse or level
- booting  output  1  1 while in BOOT
- mem_we  output  1  to data memory write enable
- mem_a  output  32  to data memory address
- mem_wd  output  32  to data memory write data
- mem_rd  input  32  from data memory asynchronous read data

## Operation
- States: BOOT and RUN, held in a 1-bit state register. Reset state is BOOT if BOOT_EN=1, otherwise RUN.
- BOOT:
  - Only the loader can be granted: l_gnt = l_req and c_gnt = 0.
  - The core request is ignored and the core stays stalled.
  - boot_done=1 at an edge moves the state to RUN.
  - A loader access granted in that same cycle completes normally.
- RUN:
  - Round-robin between requesters, using a last_gnt register (0 = core, 1 = loader).
  - One requester active: it is granted.
  - Both requesting: the requester not granted last wins.
  - last_gnt updates on every grant, including grants made in BOOT.
  - boot_done is ignored in RUN.
- Winner path: mem_a, mem_wd and mem_we = winner addr, wdata and we, combinationally in the grant cycle.
- No grant: mem_we=0, mem_a=0, mem_wd=0.
- At most one grant per cycle. c_gnt and l_gnt are never both 1.
- Read grant:
  - At the edge, mem_rd is captured into the winner's rdata register, and that requester's rvalid is set for exactly one cycle.
  - The other requester's rdata holds its value.
- Writes produce no rvalid.
- Address bits [1:0] and [31:8] pass through unmodified. The memory uses only [7:2]; alignment is not checked.
- A requester may keep req high on consecutive cycles. Each grant is one independent access.

## Timing
- Grant latency: 0 cycles (gnt in the same cycle as req, when arbitration is won). Read data latency: 1 cycle after grant.
- Write latency: the write takes effect at the grant-cycle edge.
  - A read of the same word granted in the next cycle returns the new data.
- Back-to-back throughput: one access per cycle.
- Reset values: state=BOOT (or RUN if BOOT_EN=0), last_gnt=1, c_rvalid=0, l_rvalid=0, c_rdata=0, l_rdata=0, booting=BOOT_EN.
- Reset asserted mid-operation:
  - A pending rvalid is cleared at the reset edge; no response is delivered for an access granted in that cycle.
  - The write of that cycle still reaches memory, because mem_we is combinational.
- booting falls in the first cycle after the edge at which boot_done was sampled high.

## Test plan
- Reset with BOOT_EN=1, then c_req=1 and l_req=1 for 3 cycles -> l_gnt=1 each cycle, c_gnt=0, booting=1.
- BOOT write: loader writes 0xDEADBEEF to 0x10; next cycle loader reads 0x10 -> one cycle later l_rvalid=1 and l_rdata=0xDEADBEEF, c_rvalid=0.
- Pulse boot_done with l_req=1 the same cycle -> that loader access is granted and completes, booting=0 the next cycle.
  - Then both request continuously -> grants alternate core, loader, core, loader, with the core first because last_gnt=1.
- RUN, core only: c_req held 4 cycles writing 0x1..0x4 to 0x00..0x0C, then reading back -> c_gnt=1 every cycle, reads return 0x1..0x4 in order, one per cycle, each 1 cycle after its grant.
- Reset asserted in the cycle of a granted core read of 0x08 -> c_rvalid=0 the next cycle, all outputs at their reset values.
- BOOT_EN=0: after reset, c_req=1 with l_req=0 -> c_gnt=1 in the first cycle, booting=0.
